sprite_collide: RTL
===================

Name: sprite_collide

Overview:
- Downstream consumer of the sprite pixel streams: takes per-pixel index and drawing flags from the player sprite and one monster sprite during raster scan.
- Detects pixel-exact overlap of non-transparent pixels and accumulates it over each frame.
- Reports a debounced per-frame hit, with the first overlap coordinate, to game logic (life/game-over FSM).
- Sits beside the palette/compositor stage, on the same pipeline timing as the pix outputs.

Parameters:
- CORDW, 16, signed screen coordinate width.
- COLR_BITS, 4, palette index width.
- TRANSP_IDX, 0, palette index treated as transparent (no overlap).
- MIN_OVERLAP, 4, overlapping pixels per frame required to count the frame as a collision frame (1..65535).
- CONFIRM_FRAMES, 2, consecutive collision frames required before hit latches (1..15).

Ports:
- clk  in  1  system pixel clock.
- i_rst_n  in  1  asynchronous active-low reset.
- replay  in  1  synchronous clear of all state, level.
- enable  in  1  detection armed; low = overlaps ignored.
- frame  in  1  one-cycle pulse at start of each frame.
- de  in  1  display-enable, aligned with pix inputs.
- sx  in  CORDW signed  current pixel x, aligned with pix inputs.
- sy  in  CORDW signed  current pixel y, aligned with pix inputs.
- player_drawing  in  1  player sprite active this pixel.
- player_pix  in  COLR_BITS  player palette index.
- monster_drawing  in  1  monster sprite active this pixel.
- monster_pix  in  COLR_BITS  monster palette index.
- hit  out  1  sticky collision flag.
- hit_pulse  out  1  one-cycle pulse when hit rises.
- hit_x  out  CORDW signed  x of first overlap pixel in the confirming frame.
- hit_y  out  CORDW signed  y of first overlap pixel in the confirming frame.
- overlap_cnt  out  16  overlap count of last completed frame.
- dbg_overlay  out  1  overlap debug pixel (see Optional Feature).

Behaviour:
- Overlap pixel: de & enable & player_drawing & monster_drawing & player_pix!=TRANSP_IDX & monster_pix!=TRANSP_IDX.
- Reset (i_rst_n low, async): all outputs and registers 0; state IDLE.
- replay high: same clear as reset, synchronous, priority over all other events.
- Running per-frame count cnt: 16-bit, saturates at 65535 (no wrap).
- First-overlap capture: on the first overlap pixel of a frame (cnt==0), capture sx/sy into first_x/first_y.
- FSM states: IDLE, SCAN, EVAL, LOCKED.
  - IDLE -> SCAN on frame.
  - SCAN: count overlap pixels; on frame -> EVAL.
  - EVAL (one cycle):
    - overlap_cnt<=cnt.
    - If cnt>=MIN_OVERLAP, confirm<=confirm+1 (saturate at CONFIRM_FRAMES); else confirm<=0.
    - If the new confirm value ==CONFIRM_FRAMES: hit<=1, hit_pulse<=1 for one cycle, hit_x/hit_y<=first_x/first_y, -> LOCKED.
    - Otherwise -> SCAN.
- Frame pulse coinciding with an overlap pixel: the old-frame count is snapshotted for EVAL first; the new frame's count starts at 1, and that pixel is the first overlap of the new frame.
- Any overlap pixel during the EVAL cycle counts toward the new frame.
- Latency: hit rises 1 cycle after the frame pulse that ends the confirming frame.
- LOCKED: hit held and hit_x/hit_y frozen until replay; overlap_cnt keeps updating each frame.
- enable low:
  - Overlaps ignored, so cnt stays 0 for the frame.
  - Confirm resets at the next EVAL.
  - hit is not cleared.
- frame before first SCAN (IDLE): starts scanning; no EVAL of a partial frame.

Optional Feature:
- Macro COLLIDE_DEBUG_EN.
- Defined: dbg_overlay = registered overlap pixel, 1-cycle latency vs inputs; the compositor uses it to tint overlap red.
- Undefined: dbg_overlay tied 0 and no register is inferred.

Decomposition:
- Shared package collide_pkg: CORDW and COLR_BITS constants; typedef enum logic [1:0] {IDLE, SCAN, EVAL, LOCKED} collide_state_t.
- One natural sub-module: sat_counter (parameterised width, inc/clear/saturate), used for both cnt and confirm.

Test Plan:
- Reset mid-scan with cnt=50 -> all outputs 0 immediately, state IDLE; next frame restarts scanning.
- Player/monster overlap 3 px/frame, MIN_OVERLAP=4 -> hit stays 0, overlap_cnt=3 each frame.
- Overlap 10 px/frame for 2 frames starting at (120,300), CONFIRM_FRAMES=2 -> hit and hit_pulse 1 cycle after the second frame pulse; hit_x=120, hit_y=300; overlap_cnt=10.
- Overlap frames 10, 0, 10 -> confirm resets at the middle frame, no hit; a fourth frame of 10 -> hit.
- Overlap only where monster_pix=TRANSP_IDX, or de=0, or enable=0 -> overlap_cnt=0, no hit.
- Overlap pixel on the same cycle as frame -> old frame reports its own count; new frame count starts at 1 with first_x/first_y from that pixel; then replay -> hit=0, state IDLE.

Source files
------------

// File: rtl/collide_pkg.sv
// Shared types and widths for the sprite collision detector.
// Screen coordinate / palette widths and the collision FSM state encoding.
package collide_pkg;

    localparam int CORDW     = 16;
    localparam int COLR_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EVAL,
        LOCKED
    } collide_state_t;

endpackage

// File: rtl/sprite_collide_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear and increment together restart the count at one.
module sat_counter #(
    parameter int WIDTH = 16,
    parameter int MAX   = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: restart on clear, otherwise climb until MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (cnt_q != WIDTH'(MAX))) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/sprite_collide.sv
// Player/monster pixel-overlap detector with per-frame debounced hit.
// Optional macro COLLIDE_DEBUG_EN: registered overlap debug pixel.
module sprite_collide
    import collide_pkg::*;
#(
    parameter logic [COLR_BITS-1:0] TRANSP_IDX     = '0,
    parameter int                   MIN_OVERLAP    = 4,
    parameter int                   CONFIRM_FRAMES = 2
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic                        replay,
    input  logic                        enable,
    input  logic                        frame,
    input  logic                        de,
    input  logic signed [CORDW-1:0]     sx,
    input  logic signed [CORDW-1:0]     sy,
    input  logic                        player_drawing,
    input  logic [COLR_BITS-1:0]        player_pix,
    input  logic                        monster_drawing,
    input  logic [COLR_BITS-1:0]        monster_pix,
    output logic                        hit,
    output logic                        hit_pulse,
    output logic signed [CORDW-1:0]     hit_x,
    output logic signed [CORDW-1:0]     hit_y,
    output logic [15:0]                 overlap_cnt,
    output logic                        dbg_overlay
);

    collide_state_t state_q, state_d;

    logic                    overlap;
    logic                    counting;
    logic                    cnt_clr, cnt_inc;
    logic                    cap;
    logic                    conf_clr, conf_inc;
    logic                    enough;
    logic                    confirmed;
    logic [15:0]             cnt_q;
    logic [3:0]              conf_q;

    logic                    hit_q, hit_d;
    logic                    hit_pulse_q, hit_pulse_d;
    logic                    ovl_upd_q, ovl_upd_d;
    logic signed [CORDW-1:0] hit_x_q, hit_x_d;
    logic signed [CORDW-1:0] hit_y_q, hit_y_d;
    logic signed [CORDW-1:0] first_x_q, first_x_d;
    logic signed [CORDW-1:0] first_y_q, first_y_d;
    logic signed [CORDW-1:0] snap_x_q, snap_x_d;
    logic signed [CORDW-1:0] snap_y_q, snap_y_d;
    logic [15:0]             snap_cnt_q, snap_cnt_d;
    logic [15:0]             overlap_cnt_q, overlap_cnt_d;

    assign overlap = de & enable & player_drawing & monster_drawing
                   & (player_pix != TRANSP_IDX)
                   & (monster_pix != TRANSP_IDX);

    // A frame pulse in IDLE already belongs to the first scanned frame.
    assign counting = frame | (state_q != IDLE);
    assign cnt_clr  = replay | frame | (state_q == IDLE);
    assign cnt_inc  = ~replay & overlap & counting;
    assign cap      = cnt_inc & (frame | (cnt_q == '0));

    sat_counter #(
        .WIDTH (16),
        .MAX   (65535)
    ) u_cnt (
        .clk   (clk),
        .rst_n (i_rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .q     (cnt_q)
    );

    sat_counter #(
        .WIDTH (4),
        .MAX   (CONFIRM_FRAMES)
    ) u_conf (
        .clk   (clk),
        .rst_n (i_rst_n),
        .clr   (conf_clr),
        .inc   (conf_inc),
        .q     (conf_q)
    );

    assign enough    = snap_cnt_q >= 16'(MIN_OVERLAP);
    // Saturated confirm+1 reaches the target exactly when q is one short.
    assign confirmed = enough & (conf_q >= 4'(CONFIRM_FRAMES - 1));

    // Frame-boundary snapshot and first-overlap coordinate capture.
    always_comb begin
        first_x_d  = cap ? sx : first_x_q;
        first_y_d  = cap ? sy : first_y_q;
        snap_cnt_d = frame ? cnt_q : snap_cnt_q;
        snap_x_d   = frame ? first_x_q : snap_x_q;
        snap_y_d   = frame ? first_y_q : snap_y_q;
        if (replay) begin
            first_x_d  = '0;
            first_y_d  = '0;
            snap_cnt_d = '0;
            snap_x_d   = '0;
            snap_y_d   = '0;
        end
    end

    // Next-state and registered outputs of the collision FSM.
    always_comb begin
        state_d       = state_q;
        hit_d         = hit_q;
        hit_pulse_d   = 1'b0;
        hit_x_d       = hit_x_q;
        hit_y_d       = hit_y_q;
        overlap_cnt_d = overlap_cnt_q;
        ovl_upd_d     = 1'b0;
        conf_clr      = 1'b0;
        conf_inc      = 1'b0;
        if (ovl_upd_q) begin
            overlap_cnt_d = snap_cnt_q;
        end
        if (replay) begin
            state_d       = IDLE;
            hit_d         = 1'b0;
            hit_x_d       = '0;
            hit_y_d       = '0;
            overlap_cnt_d = '0;
            conf_clr      = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame) state_d = SCAN;
                end
                SCAN: begin
                    if (frame) state_d = EVAL;
                end
                EVAL: begin
                    overlap_cnt_d = snap_cnt_q;
                    conf_inc      = enough;
                    conf_clr      = ~enough;
                    state_d       = SCAN;
                    if (confirmed) begin
                        hit_d       = 1'b1;
                        hit_pulse_d = 1'b1;
                        hit_x_d     = snap_x_q;
                        hit_y_d     = snap_y_q;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    ovl_upd_d = frame;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            hit_q         <= 1'b0;
            hit_pulse_q   <= 1'b0;
            hit_x_q       <= '0;
            hit_y_q       <= '0;
            overlap_cnt_q <= '0;
            ovl_upd_q     <= 1'b0;
            first_x_q     <= '0;
            first_y_q     <= '0;
            snap_cnt_q    <= '0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
        end else begin
            state_q       <= state_d;
            hit_q         <= hit_d;
            hit_pulse_q   <= hit_pulse_d;
            hit_x_q       <= hit_x_d;
            hit_y_q       <= hit_y_d;
            overlap_cnt_q <= overlap_cnt_d;
            ovl_upd_q     <= ovl_upd_d;
            first_x_q     <= first_x_d;
            first_y_q     <= first_y_d;
            snap_cnt_q    <= snap_cnt_d;
            snap_x_q      <= snap_x_d;
            snap_y_q      <= snap_y_d;
        end
    end

    assign hit         = hit_q;
    assign hit_pulse   = hit_pulse_q;
    assign hit_x       = hit_x_q;
    assign hit_y       = hit_y_q;
    assign overlap_cnt = overlap_cnt_q;

`ifdef COLLIDE_DEBUG_EN
    logic dbg_q, dbg_d;

    assign dbg_d = replay ? 1'b0 : overlap;

    // Overlap pixel delayed one cycle for the compositor tint.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbg_q <= 1'b0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign dbg_overlay = dbg_q;
`else
    assign dbg_overlay = 1'b0;
`endif

endmodule
